trig_readout_scheduler: RTL and testbench

TRIG_READOUT_SCHEDULER -- requirements
Module: trig_readout_scheduler

---
 rtl/trig_readout_scheduler.sv | 149 ++++++++++++++
 tb/tb_trig_readout_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_readout_scheduler.sv
// Trigger readout scheduler: pops one TTC trigger word at a time, hands it
// to the command manager, waits for completion and reports it upstream.
module trig_readout_scheduler #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         fifo_valid,
   input  logic [127:0] fifo_data,
   output logic         fifo_ready,
   output logic         rd_req,
   output logic [23:0]  rd_trig_num,
   output logic [23:0]  rd_event_cnt,
   output logic [4:0]   rd_trig_type,
   output logic [43:0]  rd_timestamp,
   output logic         rd_empty,
   input  logic         rd_ack,
   input  logic         rd_done,
   input  logic [22:0]  rd_size,
   output logic         readout_done,
   output logic [22:0]  readout_size,
   output logic [2:0]   state,
   output logic [31:0]  event_count,
   output logic [31:0]  empty_count,
   output logic         error_timeout
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQUEST   = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_REPORT    = 3'd3,
      S_ERROR     = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [23:0] tmo_q, tmo_d;
   logic [22:0] size_q, size_d;
   logic [31:0] evt_q, evt_d;
   logic [31:0] emp_q, emp_d;

   logic [23:0] trig_num_q;
   logic [23:0] event_cnt_q;
   logic [4:0]  trig_type_q;
   logic [43:0] timestamp_q;
   logic        empty_q;

   logic        accept;
   logic        unused_fifo_bits;

   assign unused_fifo_bits = ^fifo_data[127:98];

   assign fifo_ready = (state_q == S_IDLE) & enable;
   assign accept     = fifo_valid & fifo_ready;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      size_d  = size_q;
      evt_d   = evt_q;
      emp_d   = emp_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_REQUEST;
         end
         S_REQUEST: begin
            if (rd_ack) begin
               tmo_d = '0;
               if (rd_done) begin
                  size_d  = rd_size;
                  state_d = S_REPORT;
               end else begin
                  state_d = S_WAIT_DONE;
               end
            end
         end
         S_WAIT_DONE: begin
            // completion on the final timeout cycle still wins
            if (rd_done) begin
               size_d  = rd_size;
               state_d = S_REPORT;
            end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + 24'd1;
            end
         end
         S_REPORT: begin
            evt_d   = evt_q + 32'd1;
            emp_d   = emp_q + {31'd0, empty_q};
            state_d = S_IDLE;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
         size_q  <= '0;
         evt_q   <= '0;
         emp_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         size_q  <= size_d;
         evt_q   <= evt_d;
         emp_q   <= emp_d;
      end
   end

   // Word fields stay frozen for the whole event once accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trig_num_q  <= '0;
         event_cnt_q <= '0;
         trig_type_q <= '0;
         timestamp_q <= '0;
         empty_q     <= 1'b0;
      end else if (accept) begin
         timestamp_q <= fifo_data[43:0];
         trig_num_q  <= fifo_data[67:44];
         event_cnt_q <= fifo_data[91:68];
         trig_type_q <= fifo_data[96:92];
         empty_q     <= fifo_data[97];
      end
   end

   assign rd_req        = (state_q == S_REQUEST);
   assign readout_done  = (state_q == S_REPORT);
   assign error_timeout = (state_q == S_ERROR);
   assign readout_size  = size_q;
   assign state         = state_q;
   assign event_count   = evt_q;
   assign empty_count   = emp_q;
   assign rd_trig_num   = trig_num_q;
   assign rd_event_cnt  = event_cnt_q;
   assign rd_trig_type  = trig_type_q;
   assign rd_timestamp  = timestamp_q;
   assign rd_empty      = empty_q;

endmodule

// File: tb/tb_trig_readout_scheduler.sv
// Directed bench for trig_readout_scheduler (built with a 16-cycle timeout).
module tb_trig_readout_scheduler;

   logic         clk;
   logic         reset_n;
   logic         enable;
   logic         fifo_valid;
   logic [127:0] fifo_data;
   logic         fifo_ready;
   logic         rd_req;
   logic [23:0]  rd_trig_num;
   logic [23:0]  rd_event_cnt;
   logic [4:0]   rd_trig_type;
   logic [43:0]  rd_timestamp;
   logic         rd_empty;
   logic         rd_ack;
   logic         rd_done;
   logic [22:0]  rd_size;
   logic         readout_done;
   logic [22:0]  readout_size;
   logic [2:0]   state;
   logic [31:0]  event_count;
   logic [31:0]  empty_count;
   logic         error_timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int accepts = 0;

   trig_readout_scheduler #(.TIMEOUT_CYCLES(24'd16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .fifo_valid    (fifo_valid),
      .fifo_data     (fifo_data),
      .fifo_ready    (fifo_ready),
      .rd_req        (rd_req),
      .rd_trig_num   (rd_trig_num),
      .rd_event_cnt  (rd_event_cnt),
      .rd_trig_type  (rd_trig_type),
      .rd_timestamp  (rd_timestamp),
      .rd_empty      (rd_empty),
      .rd_ack        (rd_ack),
      .rd_done       (rd_done),
      .rd_size       (rd_size),
      .readout_done  (readout_done),
      .readout_size  (readout_size),
      .state         (state),
      .event_count   (event_count),
      .empty_count   (empty_count),
      .error_timeout (error_timeout)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (readout_done === 1'b1) pulses++;
      if (fifo_valid === 1'b1 && fifo_ready === 1'b1) accepts++;
   end

   function automatic logic [127:0] mk_word(input logic [43:0] ts,
                                            input logic [23:0] tn,
                                            input logic [23:0] ec,
                                            input logic [4:0]  tt,
                                            input logic        em);
      mk_word = {30'h2AAA_5555, em, tt, ec, tn, ts};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      enable     = 1'b0;
      fifo_valid = 1'b0;
      fifo_data  = '0;
      rd_ack     = 1'b0;
      rd_done    = 1'b0;
      rd_size    = '0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      enable     = 1'b0;
      fifo_valid = 1'b0;
      fifo_data  = '0;
      rd_ack     = 1'b0;
      rd_done    = 1'b0;
      rd_size    = '0;
      #5;
      n_tests++;
      if (state !== 3'd0) begin
         $display("FAIL reset_state got %0d want 0", state); n_fail++;
      end
      n_tests++;
      if ({rd_req, readout_done, error_timeout} !== 3'b000) begin
         $display("FAIL reset_flags got %b want 000",
                  {rd_req, readout_done, error_timeout}); n_fail++;
      end
      n_tests++;
      if (event_count !== 32'd0 || empty_count !== 32'd0 ||
          readout_size !== 23'd0) begin
         $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0",
                  event_count, empty_count, readout_size); n_fail++;
      end
      n_tests++;
      if (rd_trig_num !== 24'd0 || rd_event_cnt !== 24'd0 ||
          rd_trig_type !== 5'd0 || rd_timestamp !== 44'd0 ||
          rd_empty !== 1'b0) begin
         $display("FAIL reset_fields got %0d/%0d/%0d/%0d/%b want zeros",
                  rd_trig_num, rd_event_cnt, rd_trig_type,
                  rd_timestamp, rd_empty); n_fail++;
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_event();
      int p0;
      do_reset();
      p0 = pulses;
      enable     = 1'b1;
      fifo_valid = 1'b1;
      fifo_data  = mk_word(44'h123_4567_89AB, 24'd5, 24'd3, 5'd1, 1'b0);
      #1;
      n_tests++;
      if (fifo_ready !== 1'b1) begin
         $display("FAIL idle_ready got %b want 1", fifo_ready); n_fail++;
      end
      tick();
      fifo_valid = 1'b0;
      n_tests++;
      if (state !== 3'd1 || rd_req !== 1'b1 || fifo_ready !== 1'b0) begin
         $display("FAIL accept_req got st=%0d req=%b rdy=%b want 1/1/0",
                  state, rd_req, fifo_ready); n_fail++;
      end
      n_tests++;
      if (rd_trig_num !== 24'd5 || rd_event_cnt !== 24'd3 ||
          rd_trig_type !== 5'd1 || rd_empty !== 1'b0 ||
          rd_timestamp !== 44'h123_4567_89AB) begin
         $display("FAIL latch_fields got %0d/%0d/%0d/%b/%h want 5/3/1/0/123456789ab",
                  rd_trig_num, rd_event_cnt, rd_trig_type, rd_empty,
                  rd_timestamp); n_fail++;
      end
      tick();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      n_tests++;
      if (state !== 3'd2 || rd_req !== 1'b0) begin
         $display("FAIL ack_wait got st=%0d req=%b want 2/0",
                  state, rd_req); n_fail++;
      end
      repeat (9) tick();
      rd_done = 1'b1;
      rd_size = 23'd1030;
      tick();
      rd_done = 1'b0;
      rd_size = 23'd7;
      n_tests++;
      if (readout_done !== 1'b1 || readout_size !== 23'd1030) begin
         $display("FAIL report got done=%b size=%0d want 1/1030",
                  readout_done, readout_size); n_fail++;
      end
      tick();
      tick();
      n_tests++;
      if (state !== 3'd0 || event_count !== 32'd1 ||
          empty_count !== 32'd0 || pulses - p0 !== 1) begin
         $display("FAIL single_end got st=%0d ev=%0d em=%0d pulses=%0d want 0/1/0/1",
                  state, event_count, empty_count, pulses - p0); n_fail++;
      end
   endtask

   task automatic test_empty_direct();
      do_reset();
      enable     = 1'b1;
      fifo_valid = 1'b1;
      fifo_data  = mk_word(44'd77, 24'd9, 24'd4, 5'd2, 1'b1);
      tick();
      fifo_valid = 1'b0;
      rd_ack     = 1'b1;
      rd_done    = 1'b1;
      rd_size    = 23'd2;
      tick();
      rd_ack  = 1'b0;
      rd_done = 1'b0;
      n_tests++;
      if (state !== 3'd3 || readout_size !== 23'd2 || rd_empty !== 1'b1) begin
         $display("FAIL empty_direct got st=%0d size=%0d em=%b want 3/2/1",
                  state, readout_size, rd_empty); n_fail++;
      end
      tick();
      n_tests++;
      if (event_count !== 32'd1 || empty_count !== 32'd1) begin
         $display("FAIL empty_counts got %0d/%0d want 1/1",
                  event_count, empty_count); n_fail++;
      end
   endtask

   task automatic to_wait_done();
      do_reset();
      enable     = 1'b1;
      fifo_valid = 1'b1;
      fifo_data  = mk_word(44'd1, 24'd2, 24'd3, 5'd4, 1'b0);
      tick();
      fifo_valid = 1'b0;
      rd_ack     = 1'b1;
      tick();
      rd_ack = 1'b0;
   endtask

   task automatic test_timeout();
      int a0;
      to_wait_done();
      fifo_valid = 1'b1;
      repeat (15) tick();
      n_tests++;
      if (state !== 3'd2) begin
         $display("FAIL tmo_early got st=%0d want 2", state); n_fail++;
      end
      a0 = accepts;
      tick();
      n_tests++;
      if (state !== 3'd4 || error_timeout !== 1'b1) begin
         $display("FAIL tmo_error got st=%0d err=%b want 4/1",
                  state, error_timeout); n_fail++;
      end
      repeat (4) tick();
      n_tests++;
      if (state !== 3'd4 || fifo_ready !== 1'b0 || rd_req !== 1'b0 ||
          accepts != a0) begin
         $display("FAIL tmo_hold got st=%0d rdy=%b req=%b acc=%0d want 4/0/0/0",
                  state, fifo_ready, rd_req, accepts - a0); n_fail++;
      end
      reset_n = 1'b0;
      #2;
      n_tests++;
      if (state !== 3'd0 || error_timeout !== 1'b0) begin
         $display("FAIL tmo_reset got st=%0d err=%b want 0/0",
                  state, error_timeout); n_fail++;
      end
      tick();
      reset_n = 1'b1;
      #1;
      n_tests++;
      if (fifo_ready !== 1'b1) begin
         $display("FAIL post_reset_ready got %b want 1", fifo_ready); n_fail++;
      end
      fifo_valid = 1'b0;
   endtask

   task automatic test_done_priority();
      to_wait_done();
      repeat (15) tick();
      rd_done = 1'b1;
      rd_size = 23'd55;
      tick();
      rd_done = 1'b0;
      n_tests++;
      if (state !== 3'd3 || error_timeout !== 1'b0 ||
          readout_size !== 23'd55) begin
         $display("FAIL done_priority got st=%0d err=%b size=%0d want 3/0/55",
                  state, error_timeout, readout_size); n_fail++;
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int p0;
      int a0;
      do_reset();
      p0 = pulses;
      a0 = accepts;
      enable     = 1'b1;
      fifo_valid = 1'b1;
      rd_ack     = 1'b1;
      rd_done    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fifo_data = mk_word(44'd1000 + 44'(i), 24'd100 + 24'(i),
                             24'd0, 5'd3, 1'b0);
         rd_size   = 23'd10 + 23'(i);
         tick();
         n_tests++;
         if (state !== 3'd1 || rd_trig_num !== 24'd100 + 24'(i)) begin
            $display("FAIL b2b_accept%0d got st=%0d tn=%0d want 1/%0d",
                     i, state, rd_trig_num, 100 + i); n_fail++;
         end
         fifo_data = mk_word(44'd0, 24'hFFFFFF, 24'd0, 5'd0, 1'b0);
         tick();
         n_tests++;
         if (readout_done !== 1'b1 || readout_size !== 23'd10 + 23'(i)) begin
            $display("FAIL b2b_report%0d got done=%b size=%0d want 1/%0d",
                     i, readout_done, readout_size, 10 + i); n_fail++;
         end
         tick();
      end
      fifo_valid = 1'b0;
      rd_ack     = 1'b0;
      rd_done    = 1'b0;
      tick();
      n_tests++;
      if (event_count !== 32'd3 || pulses - p0 !== 3 || accepts - a0 !== 3) begin
         $display("FAIL b2b_totals got ev=%0d pulses=%0d acc=%0d want 3/3/3",
                  event_count, pulses - p0, accepts - a0); n_fail++;
      end
   endtask

   task automatic test_enable_drop();
      int p0;
      int a0;
      to_wait_done();
      p0 = pulses;
      enable = 1'b0;
      tick();
      rd_done = 1'b1;
      rd_size = 23'd300;
      tick();
      rd_done    = 1'b0;
      fifo_valid = 1'b1;
      a0 = accepts;
      n_tests++;
      if (readout_done !== 1'b1 || readout_size !== 23'd300) begin
         $display("FAIL en_drop_report got done=%b size=%0d want 1/300",
                  readout_done, readout_size); n_fail++;
      end
      repeat (3) tick();
      n_tests++;
      if (state !== 3'd0 || fifo_ready !== 1'b0 || accepts != a0 ||
          pulses - p0 !== 1 || event_count !== 32'd1) begin
         $display("FAIL en_drop_idle got st=%0d rdy=%b acc=%0d pulses=%0d ev=%0d want 0/0/0/1/1",
                  state, fifo_ready, accepts - a0, pulses - p0,
                  event_count); n_fail++;
      end
      enable = 1'b1;
      #1;
      n_tests++;
      if (fifo_ready !== 1'b1) begin
         $display("FAIL en_restore got %b want 1", fifo_ready); n_fail++;
      end
      fifo_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_event();
      int p0;
      to_wait_done();
      p0 = pulses;
      reset_n = 1'b0;
      #2;
      n_tests++;
      if (state !== 3'd0 || rd_req !== 1'b0 || rd_trig_num !== 24'd0) begin
         $display("FAIL mid_reset got st=%0d req=%b tn=%0d want 0/0/0",
                  state, rd_req, rd_trig_num); n_fail++;
      end
      tick();
      reset_n = 1'b1;
      rd_done = 1'b1;
      rd_size = 23'd99;
      tick();
      rd_done = 1'b0;
      repeat (2) tick();
      n_tests++;
      if (state !== 3'd0 || pulses != p0 || event_count !== 32'd0 ||
          empty_count !== 32'd0 || readout_size !== 23'd0) begin
         $display("FAIL stray_done got st=%0d pulses=%0d ev=%0d em=%0d size=%0d want 0/0/0/0/0",
                  state, pulses - p0, event_count, empty_count,
                  readout_size); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_empty_direct();
      test_timeout();
      test_done_priority();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid_event();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
